// File: rtl/mm_pkg.sv
// Shared constants and FSM state type for the
// matrix-multiply sequencer.
package mm_pkg;

  localparam int FLOAT_W = 32;
  localparam logic [FLOAT_W-1:0] FLOAT_ZERO = 32'h00000000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL_REQ,
    MUL_WAIT,
    ADD_REQ,
    ADD_WAIT,
    STORE,
    OUT
  } state_t;

endpackage

// File: rtl/mm_sequencer_if.sv
// Signal bundle between the sequencer, its job
// source/sink and the external float units.
interface mm_sequencer_if #(
  parameter int N = 6,
  parameter int M = 6,
  parameter int P = 6
) ();
  import mm_pkg::*;

  logic [0:FLOAT_W*N*M-1] matrix_A;
  logic [0:FLOAT_W*M*P-1] matrix_B;
  logic [0:FLOAT_W*N*P-1] matrix_C;
  logic a_stb, a_ack;
  logic b_stb, b_ack;
  logic c_stb, c_ack;

  logic [FLOAT_W-1:0] mul_a, mul_b, mul_z;
  logic mul_stb, mul_ack;
  logic mul_z_stb, mul_z_ack;

  logic [FLOAT_W-1:0] add_a, add_b, add_z;
  logic add_stb, add_ack;
  logic add_z_stb, add_z_ack;

  logic busy;

  modport slave (
    input  matrix_A, matrix_B,
    input  a_stb, b_stb, c_ack,
    input  mul_ack, mul_z, mul_z_stb,
    input  add_ack, add_z, add_z_stb,
    output matrix_C,
    output a_ack, b_ack, c_stb,
    output mul_a, mul_b, mul_stb,
    output mul_z_ack,
    output add_a, add_b, add_stb,
    output add_z_ack,
    output busy
  );

  modport master (
    output matrix_A, matrix_B,
    output a_stb, b_stb, c_ack,
    output mul_ack, mul_z, mul_z_stb,
    output add_ack, add_z, add_z_stb,
    input  matrix_C,
    input  a_ack, b_ack, c_stb,
    input  mul_a, mul_b, mul_stb,
    input  mul_z_ack,
    input  add_a, add_b, add_stb,
    input  add_z_ack,
    input  busy
  );

endinterface

// File: rtl/mm_index_counter.sv
// Nested i/j/k loop counter: k is the dot-product
// step, (i,j) walks C row-major.
module mm_index_counter #(
  parameter int N  = 6,
  parameter int M  = 6,
  parameter int P  = 6,
  parameter int IW = (N > 1) ? $clog2(N) : 1,
  parameter int JW = (P > 1) ? $clog2(P) : 1,
  parameter int KW = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv_k,
  input  logic          adv_ij,
  output logic [IW-1:0] i,
  output logic [JW-1:0] j,
  output logic [KW-1:0] k,
  output logic          k_last,
  output logic          ij_last
);

  assign k_last  = (k == KW'(M - 1));
  assign ij_last = (i == IW'(N - 1)) &&
                   (j == JW'(P - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (clr) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (adv_ij) begin
      k <= '0;
      if (j == JW'(P - 1)) begin
        j <= '0;
        i <= (i == IW'(N - 1)) ? '0 : i + 1'b1;
      end else begin
        j <= j + 1'b1;
      end
    end else if (adv_k) begin
      k <= k + 1'b1;
    end
  end

endmodule

// File: rtl/mm_sequencer.sv
// Matrix multiply sequencer: C = A x B using
// external float multiplier and adder units.
module mm_sequencer
  import mm_pkg::*;
#(
  parameter int N = 6,
  parameter int M = 6,
  parameter int P = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [0:FLOAT_W*N*M-1] matrix_A,
  input  logic [0:FLOAT_W*M*P-1] matrix_B,
  input  logic                   a_stb,
  output logic                   a_ack,
  input  logic                   b_stb,
  output logic                   b_ack,
  output logic [0:FLOAT_W*N*P-1] matrix_C,
  output logic                   c_stb,
  input  logic                   c_ack,
  output logic [FLOAT_W-1:0]     mul_a,
  output logic [FLOAT_W-1:0]     mul_b,
  output logic                   mul_stb,
  input  logic                   mul_ack,
  input  logic [FLOAT_W-1:0]     mul_z,
  input  logic                   mul_z_stb,
  output logic                   mul_z_ack,
  output logic [FLOAT_W-1:0]     add_a,
  output logic [FLOAT_W-1:0]     add_b,
  output logic                   add_stb,
  input  logic                   add_ack,
  input  logic [FLOAT_W-1:0]     add_z,
  input  logic                   add_z_stb,
  output logic                   add_z_ack,
  output logic                   busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int JW = (P > 1) ? $clog2(P) : 1;
  localparam int KW = (M > 1) ? $clog2(M) : 1;

  state_t state;

  logic [0:FLOAT_W*N*M-1] a_reg;
  logic [0:FLOAT_W*M*P-1] b_reg;
  logic [0:FLOAT_W*N*P-1] c_reg;
  logic [FLOAT_W-1:0]     prod;
  logic [FLOAT_W-1:0]     acc;
  logic [FLOAT_W-1:0]     a_el;
  logic [FLOAT_W-1:0]     b_el;
  logic a_got, b_got;
  logic a_ack_q, b_ack_q;
  logic a_take, b_take;

  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [KW-1:0] k;
  logic k_last, ij_last, k_zero;
  logic cnt_clr, adv_k, adv_ij;

  mm_index_counter #(
    .N (N), .M (M), .P (P),
    .IW(IW), .JW(JW), .KW(KW)
  ) u_idx (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .adv_k  (adv_k),
    .adv_ij (adv_ij),
    .i      (i),
    .j      (j),
    .k      (k),
    .k_last (k_last),
    .ij_last(ij_last)
  );

  assign k_zero  = (k == '0);
  assign cnt_clr = (state == IDLE) ||
                   (state == LOAD);
  assign adv_ij  = (state == STORE);
  assign adv_k   = !k_last && (
    ((state == MUL_WAIT) && mul_z_stb && k_zero) ||
    ((state == ADD_WAIT) && add_z_stb));

  assign a_take = a_stb && !a_got;
  assign b_take = b_stb && !b_got;

  always_comb begin
    a_el = a_reg[(int'(i) * M + int'(k)) * FLOAT_W +: FLOAT_W];
    b_el = b_reg[(int'(k) * P + int'(j)) * FLOAT_W +: FLOAT_W];
  end

  assign mul_a     = a_el;
  assign mul_b     = b_el;
  assign mul_stb   = (state == MUL_REQ);
  assign mul_z_ack = (state == MUL_WAIT) && mul_z_stb;
  assign add_a     = acc;
  assign add_b     = prod;
  assign add_stb   = (state == ADD_REQ);
  assign add_z_ack = (state == ADD_WAIT) && add_z_stb;
  assign c_stb     = (state == OUT);
  assign busy      = (state != IDLE);
  assign matrix_C  = c_reg;
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      c_reg   <= '0;
      prod    <= FLOAT_ZERO;
      acc     <= FLOAT_ZERO;
      a_got   <= 1'b0;
      b_got   <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      unique case (state)
        IDLE, LOAD: begin
          if (a_take) begin
            a_reg   <= matrix_A;
            a_got   <= 1'b1;
            a_ack_q <= 1'b1;
          end
          if (b_take) begin
            b_reg   <= matrix_B;
            b_got   <= 1'b1;
            b_ack_q <= 1'b1;
          end
          if (state == IDLE) begin
            if (a_take || b_take) state <= LOAD;
          end else if (a_got && b_got) begin
            state <= MUL_REQ;
          end
        end
        MUL_REQ: begin
          if (mul_ack) state <= MUL_WAIT;
        end
        MUL_WAIT: begin
          if (mul_z_stb) begin
            prod <= mul_z;
            // first term seeds the accumulator directly
            if (k_zero) begin
              acc   <= mul_z;
              state <= k_last ? STORE : MUL_REQ;
            end else begin
              state <= ADD_REQ;
            end
          end
        end
        ADD_REQ: begin
          if (add_ack) state <= ADD_WAIT;
        end
        ADD_WAIT: begin
          if (add_z_stb) begin
            acc   <= add_z;
            state <= k_last ? STORE : MUL_REQ;
          end
        end
        STORE: begin
          c_reg[(int'(i) * P + int'(j)) * FLOAT_W +: FLOAT_W] <= acc;
          state <= ij_last ? OUT : MUL_REQ;
        end
        OUT: begin
          if (c_ack) begin
            a_got <= 1'b0;
            b_got <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_sequencer.sv
// Randomized bench for mm_sequencer with 3-cycle
// behavioural float stubs and an integer matrix model.
module tb_mm_sequencer;
  import mm_pkg::*;

  localparam int N  = 2;
  localparam int M  = 2;
  localparam int P  = 2;
  localparam int CW = FLOAT_W * N * P;

  typedef int mat_t [4];

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mm_sequencer_if #(.N(N), .M(M), .P(P)) bus ();

  mm_sequencer #(.N(N), .M(M), .P(P)) dut (
    .clk      (clk),
    .rst      (rst),
    .matrix_A (bus.matrix_A),
    .matrix_B (bus.matrix_B),
    .a_stb    (bus.a_stb),
    .a_ack    (bus.a_ack),
    .b_stb    (bus.b_stb),
    .b_ack    (bus.b_ack),
    .matrix_C (bus.matrix_C),
    .c_stb    (bus.c_stb),
    .c_ack    (bus.c_ack),
    .mul_a    (bus.mul_a),
    .mul_b    (bus.mul_b),
    .mul_stb  (bus.mul_stb),
    .mul_ack  (bus.mul_ack),
    .mul_z    (bus.mul_z),
    .mul_z_stb(bus.mul_z_stb),
    .mul_z_ack(bus.mul_z_ack),
    .add_a    (bus.add_a),
    .add_b    (bus.add_b),
    .add_stb  (bus.add_stb),
    .add_ack  (bus.add_ack),
    .add_z    (bus.add_z),
    .add_z_stb(bus.add_z_stb),
    .add_z_ack(bus.add_z_ack),
    .busy     (bus.busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(string tag,
                       logic [CW-1:0] got,
                       logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] int2f(int v);
    logic [31:0] f;
    int e;
    e = 0;
    if (v == 0) return 32'h0;
    for (int b = 0; b < 24; b++)
      if (v[b]) e = b;
    f[31]    = 1'b0;
    f[30:23] = 8'(127 + e);
    f[22:0]  = 23'((v << (23 - e)) & 32'h7fffff);
    return f;
  endfunction

  function automatic int f2int(logic [31:0] f);
    int e;
    logic [23:0] m;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    m = {1'b1, f[22:0]};
    return int'(m >> (23 - e));
  endfunction

  function automatic logic [0:CW-1] pack(mat_t v);
    logic [0:CW-1] m;
    m = '0;
    for (int e = 0; e < 4; e++)
      m[e*32 +: 32] = int2f(v[e]);
    return m;
  endfunction

  function automatic mat_t matmul(mat_t a, mat_t b);
    mat_t c;
    for (int r = 0; r < N; r++)
      for (int q = 0; q < P; q++) begin
        c[r*P+q] = 0;
        for (int t = 0; t < M; t++)
          c[r*P+q] += a[r*M+t] * b[t*P+q];
      end
    return c;
  endfunction

  // multiplier stub
  logic m_pend, m_zs;
  logic [1:0] m_cnt;
  logic [31:0] m_res;
  int mul_cnt = 0;
  assign bus.mul_ack   = bus.mul_stb && !m_pend;
  assign bus.mul_z     = m_res;
  assign bus.mul_z_stb = m_zs;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend <= 1'b0;
      m_zs   <= 1'b0;
      m_cnt  <= 2'd0;
      m_res  <= 32'h0;
    end else if (!m_pend) begin
      if (bus.mul_stb) begin
        m_pend  <= 1'b1;
        m_cnt   <= 2'd2;
        m_res   <= int2f(f2int(bus.mul_a) * f2int(bus.mul_b));
        mul_cnt <= mul_cnt + 1;
      end
    end else if (m_zs) begin
      if (bus.mul_z_ack) begin
        m_zs   <= 1'b0;
        m_pend <= 1'b0;
      end
    end else if (m_cnt == 2'd0) begin
      m_zs <= 1'b1;
    end else begin
      m_cnt <= m_cnt - 2'd1;
    end
  end

  // adder stub
  logic s_pend, s_zs;
  logic [1:0] s_cnt;
  logic [31:0] s_res;
  int add_cnt = 0;
  assign bus.add_ack   = bus.add_stb && !s_pend;
  assign bus.add_z     = s_res;
  assign bus.add_z_stb = s_zs;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_pend <= 1'b0;
      s_zs   <= 1'b0;
      s_cnt  <= 2'd0;
      s_res  <= 32'h0;
    end else if (!s_pend) begin
      if (bus.add_stb) begin
        s_pend  <= 1'b1;
        s_cnt   <= 2'd2;
        s_res   <= int2f(f2int(bus.add_a) + f2int(bus.add_b));
        add_cnt <= add_cnt + 1;
      end
    end else if (s_zs) begin
      if (bus.add_z_ack) begin
        s_zs   <= 1'b0;
        s_pend <= 1'b0;
      end
    end else if (s_cnt == 2'd0) begin
      s_zs <= 1'b1;
    end else begin
      s_cnt <= s_cnt - 2'd1;
    end
  end

  int a_ack_cnt = 0;
  int b_ack_cnt = 0;
  always @(posedge clk) begin
    if (bus.a_ack) a_ack_cnt <= a_ack_cnt + 1;
    if (bus.b_ack) b_ack_cnt <= b_ack_cnt + 1;
  end

  task automatic offer(bit is_a, int dly);
    bit seen;
    seen = 1'b0;
    repeat (dly) @(negedge clk);
    if (is_a) bus.a_stb = 1'b1;
    else      bus.b_stb = 1'b1;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = is_a ? bus.a_ack : bus.b_ack;
    end
    if (is_a) bus.a_stb = 1'b0;
    else      bus.b_stb = 1'b0;
    if (!seen) check(is_a ? "a_ack_timeout" : "b_ack_timeout",
                     CW'(0), CW'(1));
  endtask

  task automatic wait_c(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (bus.c_stb) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_job(string tag, mat_t a, mat_t b,
                         int a_dly, int b_dly, int hold);
    logic [0:CW-1] exp_c, snap;
    int m0, s0, a0, b0;
    bit ok, stable;
    exp_c = pack(matmul(a, b));
    bus.matrix_A = pack(a);
    bus.matrix_B = pack(b);
    m0 = mul_cnt;
    s0 = add_cnt;
    a0 = a_ack_cnt;
    b0 = b_ack_cnt;
    fork
      offer(1'b1, a_dly);
      offer(1'b0, b_dly);
    join
    check({tag, "_no_early_mul"}, CW'(mul_cnt - m0), CW'(0));
    wait_c(ok);
    check({tag, "_c_stb"}, CW'(ok), CW'(1));
    check({tag, "_C"}, bus.matrix_C, exp_c);
    check({tag, "_muls"}, CW'(mul_cnt - m0), CW'(N*M*P));
    check({tag, "_adds"}, CW'(add_cnt - s0), CW'(N*(M-1)*P));
    check({tag, "_acks"},
          CW'({a_ack_cnt - a0, b_ack_cnt - b0}),
          CW'({32'd1, 32'd1}));
    snap   = bus.matrix_C;
    stable = 1'b1;
    for (int t = 0; t < hold; t++) begin
      @(negedge clk);
      if (!bus.c_stb || bus.matrix_C !== snap) stable = 1'b0;
    end
    if (hold > 0) check({tag, "_hold"}, CW'(stable), CW'(1));
    bus.c_ack = 1'b1;
    @(negedge clk);
    bus.c_ack = 1'b0;
    check({tag, "_idle"}, CW'({bus.busy, bus.c_stb}), CW'(0));
  endtask

  mat_t ma, mi, mr, mb;
  bit seen_c;

  initial begin
    bus.a_stb    = 1'b0;
    bus.b_stb    = 1'b0;
    bus.c_ack    = 1'b0;
    bus.matrix_A = '0;
    bus.matrix_B = '0;
    ma = '{1, 2, 3, 4};
    mi = '{1, 0, 0, 1};

    repeat (3) @(negedge clk);
    check("rst_outs",
          CW'({bus.busy, bus.c_stb, bus.a_ack, bus.b_ack,
               bus.mul_stb, bus.add_stb}),
          CW'(0));
    check("rst_C", bus.matrix_C, CW'(0));
    rst = 1'b1;
    @(negedge clk);

    run_job("ident", ma, mi, 0, 0, 0);
    check("ident_bits", bus.matrix_C,
          {32'h3F800000, 32'h40000000,
           32'h40400000, 32'h40800000});
    run_job("square", ma, ma, 1, 1, 0);
    check("square_bits", bus.matrix_C,
          {32'h40E00000, 32'h41200000,
           32'h41700000, 32'h41B00000});
    run_job("b_first", ma, mi, 5, 0, 0);
    run_job("hold", mi, ma, 0, 2, 20);
    run_job("after_hold", ma, ma, 0, 0, 0);

    // abandon a job during its third multiply
    bus.matrix_A = pack(ma);
    bus.matrix_B = pack(ma);
    begin
      int m0;
      bit reached;
      m0 = mul_cnt;
      reached = 1'b0;
      fork
        offer(1'b1, 0);
        offer(1'b0, 0);
      join
      for (int t = 0; t < 200 && !reached; t++) begin
        @(negedge clk);
        reached = (mul_cnt - m0 == 3);
      end
      check("rst_reach_mul3", CW'(reached), CW'(1));
    end
    rst = 1'b0;
    #1;
    check("midrst_outs",
          CW'({bus.busy, bus.c_stb, bus.mul_stb,
               bus.mul_z_ack, bus.a_ack, bus.b_ack}),
          CW'(0));
    check("midrst_C", bus.matrix_C, CW'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen_c = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus.c_stb || bus.busy) seen_c = 1'b1;
    end
    check("midrst_quiet", CW'(seen_c), CW'(0));
    run_job("post_rst", ma, ma, 0, 0, 0);

    for (int n = 0; n < 4; n++) begin
      for (int e = 0; e < 4; e++) begin
        mr[e] = int'($urandom_range(0, 9));
        mb[e] = int'($urandom_range(0, 9));
      end
      run_job($sformatf("rand%0d", n), mr, mb,
              int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)),
              int'($urandom_range(0, 4)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mm_sequencer.md
MM_SEQUENCER -- requirements
Module: mm_sequencer

Interface
REQ-001 Parameter N, default 6: rows of A and C.
REQ-002 Parameter M, default 6: columns of A and rows of B (dot-product length, >=1).
REQ-003 Parameter P, default 6: columns of B and C.
REQ-004 Port clk, input, 1: single clock; all state on rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port matrix_A, input, [0:32*N*M-1]: A, IEEE-754 single; element (r,c) at bits [(r*M+c)*32 +: 32].
REQ-007 Port matrix_B, input, [0:32*M*P-1]: B; element (r,c) at [(r*P+c)*32 +: 32].
REQ-008 Port a_stb/a_ack, input/output, 1 each: A-operand handshake.
REQ-009 Port b_stb/b_ack, input/output, 1 each: B-operand handshake.
REQ-010 Port matrix_C, output, [0:32*N*P-1]: result; element (r,c) at [(r*P+c)*32 +: 32].
REQ-011 Port c_stb/c_ack, output/input, 1 each: result handshake.
REQ-012 Ports mul_a, mul_b (out, 32), mul_stb (out, 1), mul_ack (in, 1): operand handshake to the external float multiplier.
REQ-013 Ports mul_z (in, 32), mul_z_stb (in, 1), mul_z_ack (out, 1): multiplier result handshake.
REQ-014 Ports add_a, add_b, add_stb, add_ack, add_z, add_z_stb, add_z_ack: same as REQ-012/013 for the external float adder.
REQ-015 Port busy, output, 1: high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, MUL_REQ, MUL_WAIT, ADD_REQ, ADD_WAIT, STORE, OUT.
REQ-017 In IDLE/LOAD, a_stb high while A is not captured SHALL register matrix_A and pulse a_ack for exactly one cycle; B is handled likewise and independently.
REQ-018 A and B SHALL be accepted in either order or in the same cycle; IDLE->LOAD on the first capture; LOAD->MUL_REQ the cycle after both are captured, with i=j=k=0.
REQ-019 a_ack/b_ack SHALL stay low outside IDLE/LOAD; a_stb/b_stb SHALL be ignored there.
REQ-020 MUL_REQ SHALL drive mul_a=A(i,k), mul_b=B(k,j), mul_stb=1, holding them stable until mul_ack=1 is sampled, then go to MUL_WAIT with mul_stb low.
REQ-021 In MUL_WAIT, mul_z_stb=1 SHALL capture mul_z into the product register and assert mul_z_ack for that one cycle.
REQ-022 For k=0 the product SHALL load the accumulator directly with no add; for k>0, ADD_REQ/ADD_WAIT SHALL perform acc <- acc + product using the same protocol as REQ-020/021.
REQ-023 After each product (k=0) or sum (k>0): if k<M-1, k increments and the FSM goes to MUL_REQ; else STORE.
REQ-024 STORE SHALL write acc to C(i,j) in one cycle, reset k to 0, advance j (wrapping at P to 0 and incrementing i), and go to MUL_REQ, or to OUT after (N-1,P-1).
REQ-025 OUT SHALL hold c_stb=1 with matrix_C stable until c_ack=1 is sampled, then drop c_stb, clear the capture flags, and return to IDLE.
REQ-026 c_ack outside OUT, and mul_z_stb/add_z_stb outside their WAIT states, SHALL be ignored.
REQ-027 Per job, exactly N*M*P multiplier and N*(M-1)*P adder transactions SHALL occur; with M=1, the adder is never used.
REQ-028 matrix_C SHALL keep the last result until overwritten element-by-element by the next job.

Reset
REQ-029 When rst=0, the block SHALL asynchronously enter IDLE, clear the counters, capture flags, acc and matrix_C (all zero), and drive every strobe/ack output and busy to 0.
REQ-030 Reset asserted mid-job SHALL abandon the job with no c_stb; after release, new a_stb/b_stb are required.

Structure
REQ-031 Shared package mm_pkg SHALL hold the FLOAT_W=32 constant, the FLOAT_ZERO=32'h00000000 constant and the state typedef.
REQ-032 The i/j/k nested counter with wrap and last flags SHALL be a sub-module, mm_index_counter.

Verification
REQ-033 Bench SHALL use fixed-latency behavioural float mul/add stubs (3 cycles, ack on first strobe cycle).
REQ-034 N=M=P=2, A=[3F800000,40000000,40400000,40800000], B=identity -> C=A, with 8 multiplies and 4 adds.
REQ-035 Same A, B=A -> C=[40E00000,41200000,41700000,41B00000] (7,10,15,22).
REQ-036 b_stb 5 cycles before a_stb -> b_ack and a_ack each pulse once; computation starts only after both.
REQ-037 c_ack held low 20 cycles -> c_stb and matrix_C are stable for 20 cycles; the second job then runs correctly.
REQ-038 rst=0 during the 3rd multiply -> all outputs are 0 at once, no c_stb appears, and the next job produces the correct C.
